// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: SHIFT, PINGPONG, FLASH and MIRROR patterns over
// NB_LEDS outputs, advancing one step per i_valid strobe.
//
// Ports:
//   clock      rising-edge system clock
//   i_reset    synchronous active-high reset
//   i_valid    one-cycle step strobe
//   i_reverse  direction toggle, sampled with i_valid
//   i_mode     pattern select: 0 SHIFT, 1 PINGPONG, 2 FLASH, 3 MIRROR
//   o_led      registered LED pattern
//   o_dir      direction register (0 = toward MSB / outer-to-inner)
//   o_mode     active mode register
module led_pattern_gen #(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_reverse,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_dir,
  output logic [NB_MODE-1:0] o_mode
);

  localparam int H = NB_LEDS / 2;

  generate
    if ((NB_LEDS < 4) || (NB_LEDS % 2 != 0)) begin : g_bad_leds
      $error("led_pattern_gen: NB_LEDS must be even and >= 4");
    end
    if (NB_MODE != 2) begin : g_bad_mode
      $error("led_pattern_gen: NB_MODE must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    SHIFT    = 2'd0,
    PINGPONG = 2'd1,
    FLASH    = 2'd2,
    MIRROR   = 2'd3
  } mode_e;

  logic [NB_LEDS-1:0] led_q, led_d;
  logic               dir_q, dir_d;
  mode_e              mode_q, mode_d;

  localparam logic [NB_LEDS-1:0] ALL_ONES = {NB_LEDS{1'b1}};
  localparam logic [NB_LEDS-1:0] BIT0 =
    {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] BIT1 =
    {{(NB_LEDS-2){1'b0}}, 2'b10};
  localparam logic [NB_LEDS-1:0] BIT_MSB =
    {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] BIT_MSB1 =
    {2'b01, {(NB_LEDS-2){1'b0}}};

  // Mirror pair p lights bit p and its mirror image.
  function automatic logic [NB_LEDS-1:0] pair_pat(input int p);
    logic [NB_LEDS-1:0] r;
    r = '0;
    for (int k = 0; k < NB_LEDS; k++) begin
      if ((k == p) || (k == NB_LEDS - 1 - p)) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [NB_LEDS-1:0] start_pat(
    input mode_e m,
    input logic  d
  );
    logic [NB_LEDS-1:0] r;
    r = '0;
    unique case (m)
      SHIFT, PINGPONG: r = d ? BIT_MSB : BIT0;
      FLASH:           r = ALL_ONES;
      MIRROR:          r = '0;
      default:         r = '0;
    endcase
    return r;
  endfunction

  logic               onehot;
  logic [NB_LEDS-1:0] rot_l, rot_r;
  logic [NB_LEDS-1:0] mir_next;
  logic               dir_tog;
  mode_e              mode_in;

  assign onehot  = $onehot(led_q);
  assign rot_l   = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
  assign rot_r   = {led_q[0], led_q[NB_LEDS-1:1]};
  assign dir_tog = dir_q ^ i_reverse;
  assign mode_in = mode_e'(i_mode);

  // Next MIRROR value: blank -> pair 0 .. pair H-1 -> blank for dir=0,
  // the reverse order for dir=1; anything unrecognised goes blank.
  always_comb begin
    mir_next = '0;
    if (led_q == '0) begin
      mir_next = dir_q ? pair_pat(H - 1) : pair_pat(0);
    end else begin
      for (int p = 0; p < H; p++) begin
        if (led_q == pair_pat(p)) begin
          if (!dir_q && (p != H - 1)) mir_next = pair_pat(p + 1);
          if (dir_q && (p != 0))      mir_next = pair_pat(p - 1);
        end
      end
    end
  end

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (i_valid) begin
      if (mode_in != mode_q) begin
        // Mode switch: load the start pattern, no step.
        mode_d = mode_in;
        dir_d  = dir_tog;
        led_d  = start_pat(mode_in, dir_tog);
      end else begin
        // Step uses the old direction; the toggle lands afterwards.
        dir_d = dir_tog;
        unique case (mode_q)
          SHIFT: begin
            if (!onehot)    led_d = start_pat(SHIFT, dir_q);
            else if (dir_q) led_d = rot_r;
            else            led_d = rot_l;
          end
          PINGPONG: begin
            if (!onehot) begin
              led_d = start_pat(PINGPONG, dir_q);
            end else if (!dir_q && led_q[NB_LEDS-1]) begin
              led_d = BIT_MSB1;
              dir_d = 1'b1;
            end else if (dir_q && led_q[0]) begin
              led_d = BIT1;
              dir_d = 1'b0;
            end else if (dir_q) begin
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end
          FLASH: begin
            if (led_q == ALL_ONES) led_d = '0;
            else                   led_d = ALL_ONES;
          end
          MIRROR: led_d = mir_next;
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      led_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= SHIFT;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end

  assign o_led  = led_q;
  assign o_dir  = dir_q;
  assign o_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: 4-LED and 8-LED instances,
// directed vectors with hand-computed expectations.
module tb_led_pattern_gen;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       v4 = 1'b0, r4 = 1'b0;
  logic [1:0] m4 = 2'd0;
  logic       v8 = 1'b0, r8 = 1'b0;
  logic [1:0] m8 = 2'd0;
  logic [3:0] led4;
  logic [7:0] led8;
  logic       dir4, dir8;
  logic [1:0] mode4, mode8;

  always #5 clock = ~clock;

  led_pattern_gen #(.NB_LEDS(4), .NB_MODE(2)) dut4 (
    .clock(clock), .i_reset(i_reset), .i_valid(v4),
    .i_reverse(r4), .i_mode(m4),
    .o_led(led4), .o_dir(dir4), .o_mode(mode4)
  );

  led_pattern_gen #(.NB_LEDS(8), .NB_MODE(2)) dut8 (
    .clock(clock), .i_reset(i_reset), .i_valid(v8),
    .i_reverse(r8), .i_mode(m8),
    .o_led(led8), .o_dir(dir8), .o_mode(mode8)
  );

  typedef struct {
    bit         sel8;
    logic [7:0] led;
    logic       dir;
    logic [1:0] mode;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Drive one cycle of stimulus to the selected instance and record
  // the state expected one edge later.
  task automatic drv(input bit sel8, input bit rst, input bit v,
                     input bit r, input logic [1:0] m,
                     input logic [7:0] eled, input bit edir,
                     input logic [1:0] emode, input string name);
    exp_t e;
    @(negedge clock);
    i_reset = rst;
    v4 = 1'b0; r4 = 1'b0;
    v8 = 1'b0; r8 = 1'b0;
    if (sel8) begin
      v8 = v; r8 = r; m8 = m;
    end else begin
      v4 = v; r4 = r; m4 = m;
    end
    e.sel8 = sel8; e.led = eled; e.dir = edir;
    e.mode = emode; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every clock edge produces a new registered state.
  always @(posedge clock) begin
    exp_t e;
    logic [10:0] act, req;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.sel8) act = {led8, dir8, mode8};
      else        act = {4'b0, led4, dir4, mode4};
      req = {e.led, e.dir, e.mode};
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: led/dir/mode got %b/%b/%b want %b/%b/%b",
                    e.name, act[10:3], act[2], act[1:0],
                    req[10:3], req[2], req[1:0]);
    end
  end

  initial begin
    // reset both instances
    drv(0, 1, 0, 0, 0, 8'h00, 0, 0, "rst4");
    drv(1, 1, 0, 0, 0, 8'h00, 0, 0, "rst8");

    // 1: SHIFT on 4 LEDs
    drv(0, 0, 1, 0, 0, 8'b0001, 0, 0, "sh_recover");
    drv(0, 0, 1, 0, 0, 8'b0010, 0, 0, "sh_1");
    drv(0, 0, 1, 0, 0, 8'b0100, 0, 0, "sh_2");
    drv(0, 0, 1, 0, 0, 8'b1000, 0, 0, "sh_3");
    drv(0, 0, 1, 0, 0, 8'b0001, 0, 0, "sh_wrap_l");
    drv(0, 0, 1, 1, 0, 8'b0010, 1, 0, "sh_rev_olddir");
    drv(0, 0, 1, 0, 0, 8'b0001, 1, 0, "sh_right");
    drv(0, 0, 1, 0, 0, 8'b1000, 1, 0, "sh_wrap_r");

    // 2: PINGPONG, mode switch with reverse brings dir back to 0
    drv(0, 0, 1, 1, 1, 8'b0001, 0, 1, "pp_load");
    drv(0, 0, 1, 0, 1, 8'b0010, 0, 1, "pp_1");
    drv(0, 0, 1, 0, 1, 8'b0100, 0, 1, "pp_2");
    drv(0, 0, 1, 0, 1, 8'b1000, 0, 1, "pp_3");
    drv(0, 0, 1, 1, 1, 8'b0100, 1, 1, "pp_bounce_hi_rev");
    drv(0, 0, 1, 0, 1, 8'b0010, 1, 1, "pp_5");
    drv(0, 0, 1, 0, 1, 8'b0001, 1, 1, "pp_6");
    drv(0, 0, 1, 0, 1, 8'b0010, 0, 1, "pp_bounce_lo");

    // 3: MIRROR on 8 LEDs
    drv(1, 0, 1, 0, 3, 8'b00000000, 0, 3, "mi_load");
    drv(1, 0, 1, 0, 3, 8'b10000001, 0, 3, "mi_p0");
    drv(1, 0, 1, 0, 3, 8'b01000010, 0, 3, "mi_p1");
    drv(1, 0, 1, 0, 3, 8'b00100100, 0, 3, "mi_p2");
    drv(1, 0, 1, 0, 3, 8'b00011000, 0, 3, "mi_p3");
    drv(1, 0, 1, 1, 3, 8'b00000000, 1, 3, "mi_blank_rev");
    drv(1, 0, 1, 0, 3, 8'b00011000, 1, 3, "mi_r_p3");
    drv(1, 0, 1, 0, 3, 8'b00100100, 1, 3, "mi_r_p2");
    drv(1, 0, 1, 0, 3, 8'b01000010, 1, 3, "mi_r_p1");
    drv(1, 0, 1, 0, 3, 8'b10000001, 1, 3, "mi_r_p0");
    drv(1, 0, 1, 0, 3, 8'b00000000, 1, 3, "mi_r_blank");

    // 4: mode changes on 4 LEDs
    drv(0, 0, 1, 0, 0, 8'b0001, 0, 0, "mc_shift");
    drv(0, 0, 1, 0, 0, 8'b0010, 0, 0, "mc_s1");
    drv(0, 0, 1, 0, 0, 8'b0100, 0, 0, "mc_s2");
    drv(0, 0, 1, 0, 2, 8'b1111, 0, 2, "mc_flash_load");
    drv(0, 0, 1, 0, 2, 8'b0000, 0, 2, "mc_flash_off");
    drv(0, 0, 1, 0, 2, 8'b1111, 0, 2, "mc_flash_on");
    drv(0, 0, 1, 0, 2, 8'b0000, 0, 2, "mc_flash_off2");
    drv(0, 0, 1, 1, 0, 8'b1000, 1, 0, "mc_shift_rev");

    // 5: hold while inputs other than i_valid wiggle
    for (int i = 0; i < 10; i++)
      drv(0, 0, 0, i[0], 2'(i), 8'b1000, 1, 0, "hold");
    drv(0, 0, 1, 0, 3, 8'b0000, 1, 3, "mi4_load");
    drv(0, 0, 1, 0, 3, 8'b0110, 1, 3, "mi4_inner");
    drv(0, 0, 1, 0, 3, 8'b1001, 1, 3, "mi4_outer");
    drv(0, 0, 1, 0, 3, 8'b0000, 1, 3, "mi4_blank");
    drv(0, 0, 1, 0, 3, 8'b0110, 1, 3, "mi4_inner2");
    drv(0, 1, 1, 1, 2, 8'b0000, 0, 0, "rst_mid");
    drv(0, 0, 1, 0, 0, 8'b0001, 0, 0, "post_rst");

    @(negedge clock);
    v4 = 1'b0; v8 = 1'b0; i_reset = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern sequencer and successor to the fixed 4-LED mirror shifter. It supports four selectable patterns, N LEDs, and run-time direction reversal. Each pattern advances one step per i_valid strobe, normally driven by the board tick divider, and drives the board LED bank directly.

Parameters:
NB_LEDS, 4, number of LEDs; must be even and >= 4 (elaboration-time check).
NB_MODE, 2, width of mode select; fixed at 2 (four modes).

Ports:
clock  input  1  system clock; all logic is on the rising edge.
i_reset  input  1  reset, synchronous, active-high.
i_valid  input  1  step enable (one-cycle strobe); no state changes without it.
i_reverse  input  1  direction toggle; sampled only when i_valid=1.
i_mode  input  NB_MODE  pattern select: 0 SHIFT, 1 PINGPONG, 2 FLASH, 3 MIRROR; sampled only when i_valid=1.
o_led  output  NB_LEDS  LED pattern, registered.
o_dir  output  1  current direction register (0 = toward MSB / outer-to-inner).
o_mode  output  NB_MODE  currently active mode register.

Behaviour:
- Reset (i_reset=1 at an edge): o_led=0, o_dir=0, o_mode=0. Reset has priority over everything, including mid-sequence.
- i_valid=0: all registers hold.
- All outputs are registered. A change is visible one cycle after the i_valid edge.
- Definitions: H=NB_LEDS/2. The start pattern per mode is:
  - SHIFT/PINGPONG: bit0 if dir=0, bit NB_LEDS-1 if dir=1.
  - FLASH: all ones.
  - MIRROR: blank (all zeros).
- Priority inside an i_valid cycle:
  1. If i_mode != o_mode: load o_mode=i_mode. If i_reverse=1, toggle dir. Load o_led with the new mode's start pattern, using the updated dir. No step occurs this cycle.
  2. Otherwise, if i_reverse=1, toggle dir. The step in this same cycle uses the OLD dir; the new dir takes effect from the next step.
  3. Step the pattern according to the mode rules below.
- SHIFT:
  - One-hot rotation with wrap. dir=0 gives rotate-left (bit k -> k+1, MSB -> bit0); dir=1 gives rotate-right.
  - Any non-one-hot o_led (e.g. 0 after reset) loads the start pattern instead of stepping.
- PINGPONG:
  - One-hot that bounces between the ends.
  - dir=0 moves toward the MSB. At o_led = bit NB_LEDS-1 with dir=0, the step goes to bit NB_LEDS-2 and dir is forced to 1.
  - The mirror case applies at bit0 with dir=1: the step goes to bit1 and dir is forced to 0.
  - On a bounce step, i_reverse is ignored (the bounce wins).
  - Non-one-hot values recover exactly as in SHIFT.
- FLASH:
  - Alternates all-ones and all-zeros on each step.
  - dir is tracked but has no effect on the output.
  - Any other value loads all ones.
- MIRROR:
  - Pair p (0..H-1) lights bits p and NB_LEDS-1-p.
  - dir=0 sequence: blank -> pair0 (outer) -> pair1 -> ... -> pair H-1 (inner) -> blank, then repeat.
  - dir=1 sequence: blank -> pair H-1 -> ... -> pair0 -> blank.
  - Any other value steps to blank.
  - For NB_LEDS=4 with dir=0 this is 0000 -> 1001 -> 0110 -> 0000.
- i_reverse with i_valid=0 is ignored.
- There is no pipelining or backpressure, so a back-to-back i_valid steps every cycle.

Test Plan:
1. Reset, then NB_LEDS=4, mode 0, dir 0, i_valid every cycle -> o_led sequence 0001 (recovery from 0), 0010, 0100, 1000, 0001. Then set i_reverse with o_led=0001 -> next o_led=0010 (old dir is used) and o_dir=1. The following step gives 0001, then 1000 (wrap).
2. Mode 1, NB_LEDS=4, from 0001 with dir 0 -> 0010, 0100, 1000, 0100 (o_dir becomes 1), 0010, 0001, 0010 (o_dir becomes 0). Assert i_reverse on the 1000 bounce step -> o_dir=1 anyway.
3. Mode 3, NB_LEDS=8, dir 0 -> 00000000, 10000001, 01000010, 00100100, 00011000, 00000000. Repeat with dir 1 -> 00011000 first and 10000001 last before blank.
4. Mode change: SHIFT at 0100, then i_valid with i_mode=2 -> o_led=1111, o_mode=2 (no step). Next step -> 0000. Then i_mode=0 with i_reverse=1 -> o_led=1000, o_dir toggled.
5. Hold and reset: with i_valid=0 for 10 cycles while i_reverse/i_mode toggle -> outputs unchanged. Reset asserted mid-MIRROR (o_led=0110, o_dir=1) -> next cycle o_led=0000, o_dir=0, o_mode=0, even if i_valid=1 in the same cycle.
